// File: rtl/os_input_scheduler_pkg.sv
// Shared endpoint map and default widths for the oversample input scheduler.
package os_input_scheduler_pkg;

   localparam int unsigned DEF_W_CHAN = 5;
   localparam int unsigned DEF_N_CHAN = 8;
   localparam int unsigned DEF_W_DATA = 18;

   // Endpoint write-bus addresses owned by the scheduler
   localparam logic [15:0] sched_en_addr      = 16'h0040;
   localparam logic [15:0] sched_ovr_clr_addr = 16'h0041;

   // 16-bit add that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/os_input_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner
// and wraps modulo N_CHAN; returns one-hot grant, binary index and any.
module rr_arbiter
   import os_input_scheduler_pkg::*;
#(
   parameter int unsigned N_CHAN = DEF_N_CHAN,
   parameter int unsigned W_IDX  = DEF_W_CHAN
) (
   input  logic [N_CHAN-1:0] req,
   input  logic [W_IDX-1:0]  last,
   output logic [N_CHAN-1:0] grant,
   output logic [W_IDX-1:0]  idx,
   output logic              any
);

   localparam int unsigned W_SEL = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

   int unsigned cand;

   // First requester found walking forward from last+1 wins
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int unsigned k = 1; k <= N_CHAN; k++) begin
         cand = (32'(last) + k) % N_CHAN;
         if (!any && req[cand[W_SEL-1:0]]) begin
            any                     = 1'b1;
            grant[cand[W_SEL-1:0]]  = 1'b1;
            idx                     = W_IDX'(cand);
         end
      end
   end

endmodule

// File: rtl/os_input_scheduler.sv
// Per-channel ADC sample holding registers serialized onto a single-issue
// dv/chan/data bus with round-robin arbitration and per-channel issue spacing.
// Optional feature macro: OS_SCHED_OVR_CNT_EN (aggregate saturating drop counter).
module os_input_scheduler
   import os_input_scheduler_pkg::*;
#(
   parameter int unsigned W_CHAN    = DEF_W_CHAN,
   parameter int unsigned N_CHAN    = DEF_N_CHAN,
   parameter int unsigned W_DATA    = DEF_W_DATA,
   parameter int unsigned MIN_GAP   = 3,
   parameter int unsigned W_WR_ADDR = 16,
   parameter int unsigned W_WR_CHAN = 16,
   parameter int unsigned W_WR_DATA = 48
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [N_CHAN-1:0]        samp_valid_in,
   input  logic [N_CHAN*W_DATA-1:0] samp_data_in,
   input  logic                     wr_en,
   input  logic [W_WR_ADDR-1:0]     wr_addr,
   input  logic [W_WR_CHAN-1:0]     wr_chan,
   input  logic [W_WR_DATA-1:0]     wr_data,
   output logic                     dv_out,
   output logic [W_CHAN-1:0]        chan_out,
   output logic [W_DATA-1:0]        data_out,
   output logic [N_CHAN-1:0]        ovr_flags_out,
   output logic [15:0]              ovr_cnt_out
);

   localparam int unsigned      W_COOL    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [W_COOL-1:0] COOL_LOAD = W_COOL'(MIN_GAP - 1);

   logic [N_CHAN-1:0] en, pend, cap, elig, grant, ovr_evt, en_clr, en_set;
   logic [W_DATA-1:0] hold [N_CHAN];
   logic [W_COOL-1:0] cool [N_CHAN];
   logic [W_CHAN-1:0] last, win_idx;
   logic              win_any;
   logic [W_DATA-1:0] win_data;
   logic              en_wr, clr_wr;
   logic              wr_data_unused;

   assign en_wr          = wr_en && (wr_addr == W_WR_ADDR'(sched_en_addr));
   assign clr_wr         = wr_en && (wr_addr == W_WR_ADDR'(sched_ovr_clr_addr)) && wr_data[0];
   assign wr_data_unused = ^wr_data[W_WR_DATA-1:1];

   // Decode enable writes, captures and eligibility per channel
   always_comb begin
      cap    = '0;
      elig   = '0;
      en_clr = '0;
      en_set = '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
         if (en_wr && (wr_chan == W_WR_CHAN'(i))) begin
            en_set[i] = wr_data[0];
            en_clr[i] = ~wr_data[0];
         end
         cap[i]  = samp_valid_in[i] & en[i];
         elig[i] = pend[i] & en[i] & (cool[i] == '0);
      end
   end

   rr_arbiter #(
      .N_CHAN (N_CHAN),
      .W_IDX  (W_CHAN)
   ) u_arb (
      .req   (elig),
      .last  (last),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // Overrun detection and winner data mux (depend on the arbiter grant)
   always_comb begin
      ovr_evt  = '0;
      win_data = '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
         ovr_evt[i] = cap[i] & pend[i] & ~grant[i] & ~en_clr[i];
         if (grant[i]) win_data = hold[i];
      end
   end

   // Channel state: enables, holding registers, pending bits, cooldowns, last winner
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         en   <= '1;
         pend <= '0;
         last <= W_CHAN'(N_CHAN - 1);
         for (int unsigned i = 0; i < N_CHAN; i++) begin
            hold[i] <= '0;
            cool[i] <= '0;
         end
      end else begin
         en <= (en | en_set) & ~en_clr;
         for (int unsigned i = 0; i < N_CHAN; i++) begin
            if (cap[i]) hold[i] <= samp_data_in[i*W_DATA +: W_DATA];
            // disabling wins over capture; capture wins over the issue clearing pend
            if (en_clr[i])      pend[i] <= 1'b0;
            else if (cap[i])    pend[i] <= 1'b1;
            else if (grant[i])  pend[i] <= 1'b0;
            if (grant[i])            cool[i] <= COOL_LOAD;
            else if (cool[i] != '0)  cool[i] <= cool[i] - W_COOL'(1);
         end
         if (win_any) last <= win_idx;
      end
   end

   // Issue registers: dv pulses one cycle, chan/data hold between issues
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         dv_out   <= 1'b0;
         chan_out <= '0;
         data_out <= '0;
      end else begin
         dv_out <= win_any;
         if (win_any) begin
            chan_out <= win_idx;
            data_out <= win_data;
         end
      end
   end

   // Sticky overrun flags; an overrun on the clearing edge survives the clear
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)       ovr_flags_out <= '0;
      else if (clr_wr)  ovr_flags_out <= ovr_evt;
      else              ovr_flags_out <= ovr_flags_out | ovr_evt;
   end

`ifdef OS_SCHED_OVR_CNT_EN
   logic [15:0] ovr_num;

   // Number of samples dropped on this edge
   always_comb begin
      ovr_num = '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
         ovr_num = ovr_num + 16'(ovr_evt[i]);
      end
   end

   // Aggregate saturating drop counter
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)       ovr_cnt_out <= '0;
      else if (clr_wr)  ovr_cnt_out <= ovr_num;
      else              ovr_cnt_out <= sat_add16(ovr_cnt_out, ovr_num);
   end
`else
   assign ovr_cnt_out = '0;
`endif

endmodule

// File: tb/tb_os_input_scheduler.sv
// Directed self-checking bench for os_input_scheduler (MIN_GAP=3, 8 channels).
module tb_os_input_scheduler;
   import os_input_scheduler_pkg::*;

   localparam int unsigned NC = 8;
   localparam int unsigned WD = 18;
`ifdef OS_SCHED_OVR_CNT_EN
   localparam logic [15:0] CNT3 = 16'd3;
   localparam logic [15:0] CNT1 = 16'd1;
`else
   localparam logic [15:0] CNT3 = 16'd0;
   localparam logic [15:0] CNT1 = 16'd0;
`endif

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b1;
   logic [NC-1:0]    samp_valid_in = '0;
   logic [NC*WD-1:0] samp_data_in = '0;
   logic             wr_en = 1'b0;
   logic [15:0]      wr_addr = '0;
   logic [15:0]      wr_chan = '0;
   logic [47:0]      wr_data = '0;
   logic             dv_out;
   logic [4:0]       chan_out;
   logic [WD-1:0]    data_out;
   logic [NC-1:0]    ovr_flags_out;
   logic [15:0]      ovr_cnt_out;

   int total = 0;
   int bad   = 0;

   os_input_scheduler #(
      .W_CHAN    (5),
      .N_CHAN    (NC),
      .W_DATA    (WD),
      .MIN_GAP   (3),
      .W_WR_ADDR (16),
      .W_WR_CHAN (16),
      .W_WR_DATA (48)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .samp_valid_in (samp_valid_in),
      .samp_data_in  (samp_data_in),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_chan       (wr_chan),
      .wr_data       (wr_data),
      .dv_out        (dv_out),
      .chan_out      (chan_out),
      .data_out      (data_out),
      .ovr_flags_out (ovr_flags_out),
      .ovr_cnt_out   (ovr_cnt_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic put(input int ch, input logic [WD-1:0] d);
      samp_valid_in[ch]         = 1'b1;
      samp_data_in[ch*WD +: WD] = d;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_chan = c;
      wr_data = d;
   endtask

   task automatic idle();
      samp_valid_in = '0;
      samp_data_in  = '0;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_chan       = '0;
      wr_data       = '0;
   endtask

   task automatic issue(input string tag, input logic [4:0] c, input logic [WD-1:0] d);
      chk({tag, "_dv"}, 32'(dv_out), 32'd1);
      chk({tag, "_chan"}, 32'(chan_out), 32'(c));
      chk({tag, "_data"}, 32'(data_out), 32'(d));
   endtask

   initial begin
      logic [WD-1:0] d;
      // reset state
      #12;
      chk("rst_dv", 32'(dv_out), 32'd0);
      chk("rst_chan", 32'(chan_out), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_flags", 32'(ovr_flags_out), 32'd0);
      chk("rst_cnt", 32'(ovr_cnt_out), 32'd0);
      rst_in = 1'b0;

      // single sample on channel 2
      put(2, 18'h00123);
      tick();
      idle();
      chk("single_e0_dv", 32'(dv_out), 32'd0);
      tick();
      issue("single_e1", 5'd2, 18'h00123);
      tick();
      chk("single_after_dv", 32'(dv_out), 32'd0);
      chk("single_hold_chan", 32'(chan_out), 32'd2);
      chk("single_hold_data", 32'(data_out), 32'(18'h00123));

      // all channels at once, fresh reset so channel 0 leads
      #3 rst_in = 1'b1;
      #2 rst_in = 1'b0;
      for (int i = 0; i < 8; i++) put(i, 18'h00100 + 18'(i));
      tick();
      idle();
      chk("all_e0_dv", 32'(dv_out), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         issue($sformatf("all_%0d", i), 5'(i), 18'h00100 + 18'(i));
      end
      tick();
      chk("all_end_dv", 32'(dv_out), 32'd0);
      chk("all_flags", 32'(ovr_flags_out), 32'd0);
      chk("all_cnt", 32'(ovr_cnt_out), 32'd0);

      // continuous channel 1, data = edge index, issues after E1/E4/E7 with 0/3/5
      for (int k = 0; k <= 8; k++) begin
         idle();
         if (k <= 5) put(1, 18'(k));
         tick();
         if (k == 1)      issue("cont_e1", 5'd1, 18'd0);
         else if (k == 4) issue("cont_e4", 5'd1, 18'd3);
         else if (k == 7) issue("cont_e7", 5'd1, 18'd5);
         else             chk($sformatf("cont_e%0d_dv", k), 32'(dv_out), 32'd0);
      end
      idle();
      chk("cont_flags", 32'(ovr_flags_out), 32'h02);
      chk("cont_cnt", 32'(ovr_cnt_out), 32'(CNT3));

      // overrun clear
      wr(sched_ovr_clr_addr, 16'd0, 48'd1);
      tick();
      idle();
      chk("clr_flags", 32'(ovr_flags_out), 32'd0);
      chk("clr_cnt", 32'(ovr_cnt_out), 32'd0);

      // disable channel 3, strobe it: no issue
      wr(sched_en_addr, 16'd3, 48'd0);
      tick();
      idle();
      put(3, 18'h2AAAA);
      tick();
      idle();
      chk("dis_e0_dv", 32'(dv_out), 32'd0);
      tick();
      chk("dis_e1_dv", 32'(dv_out), 32'd0);
      tick();
      chk("dis_e2_dv", 32'(dv_out), 32'd0);
      // out-of-range channel write must not touch channel 0
      wr(sched_en_addr, 16'd8, 48'd0);
      tick();
      wr(sched_en_addr, 16'd3, 48'd1);
      tick();
      idle();
      put(3, 18'h2BCDE);
      tick();
      idle();
      chk("reen_e0_dv", 32'(dv_out), 32'd0);
      tick();
      issue("reen_e1", 5'd3, 18'h2BCDE);
      put(0, 18'h00005);
      tick();
      idle();
      tick();
      issue("oor_ch0", 5'd0, 18'h00005);

      // mid-stream reset with outputs and flags nonzero
      tick();
      put(5, 18'h00055);
      put(6, 18'h00066);
      tick();
      idle();
      put(6, 18'h00067);
      tick();
      idle();
      issue("pre_rst", 5'd5, 18'h00055);
      chk("pre_rst_flags", 32'(ovr_flags_out), 32'h40);
      #3 rst_in = 1'b1;
      #1;
      chk("mid_rst_dv", 32'(dv_out), 32'd0);
      chk("mid_rst_chan", 32'(chan_out), 32'd0);
      chk("mid_rst_data", 32'(data_out), 32'd0);
      chk("mid_rst_flags", 32'(ovr_flags_out), 32'd0);
      chk("mid_rst_cnt", 32'(ovr_cnt_out), 32'd0);
      #1 rst_in = 1'b0;
      put(0, 18'h00A00);
      put(3, 18'h00A03);
      put(6, 18'h00A06);
      tick();
      idle();
      chk("post_rst_e0_dv", 32'(dv_out), 32'd0);
      tick();
      issue("post_rst_0", 5'd0, 18'h00A00);
      tick();
      issue("post_rst_3", 5'd3, 18'h00A03);
      tick();
      issue("post_rst_6", 5'd6, 18'h00A06);
      tick();
      chk("post_rst_end_dv", 32'(dv_out), 32'd0);

      // build a channel-1 flag, then collide the clear with a channel-4 overrun
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         idle();
         put(1, 18'(k + 16));
         tick();
         if (k == 1) issue("c1_issue", 5'd1, 18'd16);
      end
      idle();
      tick();
      tick();
      tick();
      chk("c1_flags", 32'(ovr_flags_out), 32'h02);
      chk("c1_cnt", 32'(ovr_cnt_out), 32'(CNT1));
      put(4, 18'h00040);
      tick();
      idle();
      put(4, 18'h00041);
      tick();
      idle();
      issue("c4_issue", 5'd4, 18'h00040);
      put(4, 18'h00042);
      wr(sched_ovr_clr_addr, 16'd0, 48'd1);
      tick();
      idle();
      chk("coll_dv", 32'(dv_out), 32'd0);
      chk("coll_flags", 32'(ovr_flags_out), 32'h10);
      chk("coll_cnt", 32'(ovr_cnt_out), 32'(CNT1));
      tick();
      tick();
      issue("coll_late", 5'd4, 18'h00042);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/os_input_scheduler.md
# os_input_scheduler

Serializes per-channel ADC samples onto the shared single-issue `dv/chan/data` bus that feeds the oversample filter pipeline. Each channel gets a one-deep holding register. A round-robin arbiter issues at most one sample per clock. A per-channel cooldown enforces a minimum issue spacing, so the downstream fetch/accumulate/writeback pipeline never sees a read-after-write hazard on its per-channel sum memory. Channel enables and overrun clearing are programmed over the standard endpoint write bus.

## Interface
- `W_CHAN`, 5, width of channel index
- `N_CHAN`, 8, number of channels
- `W_DATA`, 18, sample width (signed)
- `MIN_GAP`, 3, minimum clocks between two issues of the same channel (≥1)
- `W_WR_ADDR` / `W_WR_CHAN` / `W_WR_DATA`, 16 / 16 / 48, write-bus widths
- `clk_in`  in  1  sole clock, rising edge
- `rst_in`  in  1  asynchronous, active-high reset
- `samp_valid_in`  in  N_CHAN  per-channel sample strobe
- `samp_data_in`  in  N_CHAN*W_DATA  packed samples; channel i at `[i*W_DATA +: W_DATA]`
- `wr_en`  in  1  write strobe
- `wr_addr`  in  W_WR_ADDR  endpoint address
- `wr_chan`  in  W_WR_CHAN  target channel
- `wr_data`  in  W_WR_DATA  write data
- `dv_out`  out  1  issue valid, single-cycle
- `chan_out`  out  W_CHAN  issued channel
- `data_out`  out  W_DATA  issued sample
- `ovr_flags_out`  out  N_CHAN  sticky per-channel overrun flags
- `ovr_cnt_out`  out  16  aggregate dropped-sample count

## Operation
- **Enable register `en[N_CHAN-1:0]`**
  - Reset value: all ones.
  - Write `wr_en && wr_addr==sched_en_addr` sets `en[wr_chan] = wr_data[0]`.
  - A write with `wr_chan >= N_CHAN` is ignored.
- **Capture**
  - At each edge, an enabled channel with `samp_valid_in[i]` loads `hold[i]` and sets `pend[i]`.
  - Strobes on disabled channels are ignored.
  - Clearing `en[i]` also clears `pend[i]` on the same edge, with no overrun recorded.
- **Overrun**
  - Triggered when a capture hits a channel with `pend[i]` set that is not being issued on that edge.
  - The new sample overwrites the held one.
  - `ovr_flags_out[i]` is set.
  - `ovr_cnt_out` increments and saturates at 0xFFFF.
  - Capture on the same edge that channel i is issued is not an overrun; `pend[i]` stays set with the new data.
- **Eligibility**
  - A channel is eligible when `pend[i] && en[i] && cool[i]==0`.
- **Cooldown**
  - Issuing channel i loads `cool[i] = MIN_GAP-1`.
  - A nonzero `cool[i]` decrements every clock.
- **Arbitration (round-robin)**
  - Search starts at `last+1` and wraps modulo N_CHAN.
  - `last` resets to N_CHAN-1, so channel 0 wins first.
  - `last` updates only on issue.
- **Issue**
  - The winner's `hold` value is registered onto `data_out` and its index onto `chan_out`.
  - `dv_out=1` for exactly one cycle.
  - The winner's `pend` clears unless it is re-captured on the same edge.
  - With no eligible channel: `dv_out=0`; `chan_out` and `data_out` hold their last values.
- **Overrun clear**
  - Write `wr_addr==sched_ovr_clr_addr` with `wr_data[0]=1` zeroes all flags and the counter.
  - If an overrun event occurs on the same edge, that event wins: its flag is set and the counter reads 1.

## Timing
- **Asynchronous reset**
  - Takes effect immediately with no clock edge.
  - Zeroes `dv_out`, `chan_out`, `data_out`, `ovr_flags_out`, `ovr_cnt_out`, all `pend`, `hold` and `cool`.
  - Sets `en` to all ones and `last` to N_CHAN-1.
  - Deassertion is assumed synchronized upstream.
- **Latency**
  - A sample captured at edge E0 can appear on `dv_out` after edge E0+1 at the earliest (2-edge latency).
- **Throughput**
  - Up to 1 issue per clock across channels.
  - Per channel, at most 1 issue per MIN_GAP clocks.
- **Backpressure**
  - None; downstream always accepts.
- **Cooldown boundary**
  - `MIN_GAP=1` disables spacing: back-to-back issues of the same channel are allowed.

## Configuration
- **`OS_SCHED_OVR_CNT_EN` defined:** the aggregate 16-bit saturating drop counter is implemented as described.
- **Not defined:** the counter logic is omitted, `ovr_cnt_out` is tied to 0, and the sticky flags are unchanged.

## Structure
- The shared endpoint-map package holds:
  - address constants `sched_en_addr` and `sched_ovr_clr_addr`;
  - the common `W_CHAN`, `W_DATA` and `N_CHAN` defaults.
- One sub-module, `rr_arbiter`:
  - parameterized by N_CHAN;
  - inputs: request vector and `last`;
  - outputs: one-hot grant, binary index and `any`;
  - purely combinational.
- Cooldown counters, capture logic and output registers live in the top module.

## Test plan
- **Single sample:** channel 2 strobed with 18'h00123 at E0 → `dv_out=1`, `chan_out=2`, `data_out=18'h00123` in the cycle after E1; `dv_out=0` thereafter.
- **All channels at once:** all 8 strobed at E0, `MIN_GAP=3` → issues of channels 0,1,…,7 on 8 consecutive cycles; no overruns.
- **Continuous single channel:**
  - Stimulus: channel 1 strobed every edge E0..E5, with data equal to the edge index.
  - Issues occur after E1, E4 and E7, carrying data 0, 3 and 5.
  - `ovr_flags_out[1]=1`.
  - `ovr_cnt_out=3` with the macro defined, 0 without it.
- **Channel disable:**
  - Write `en[3]=0`, then strobe channel 3 → no issue.
  - Re-enable and strobe → issue after 2 edges.
- **Mid-stream reset:** assert `rst_in` between edges while channels are pending → all outputs 0 immediately. After release, the first issued channel is 0 if it is strobed along with the others.
- **Clear/overrun collision:** an overrun-clear write on the same edge as a channel-4 overrun → `ovr_flags_out=8'h10`, `ovr_cnt_out=1`.
